// File: rtl/m68k_bus_pkg.sv
// Shared encodings for the 68000 bus master: sizes, error codes, strobe levels and FSM states.
package m68k_bus_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_WORD   = 2'b01;
    localparam logic [1:0] SIZE_LONG   = 2'b10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ADDR    = 2'b01;
    localparam logic [1:0] ERR_BUS     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic DS_ON     = 1'b0;
    localparam logic DS_OFF    = 1'b1;
    localparam logic AS_STROBE = 1'b0;
    localparam logic AS_OFF    = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_END,
        ST_DONE
    } state_e;

    // Bus word for the current transfer; a long sends its high half first.
    function automatic logic [15:0] write_lane(logic [31:0] wdata, logic [1:0] size, logic second);
        if (size == SIZE_BYTE)
            return {wdata[7:0], wdata[7:0]};
        else if (size == SIZE_LONG && !second)
            return wdata[31:16];
        else
            return wdata[15:0];
    endfunction

endpackage

// File: rtl/m68k_bus_if.sv
// Core request/response channel plus the external 68000 pin group.
interface m68k_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_fc;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [22:0] A;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic [15:0] D_IN;
    logic        DTACK;
    logic        BERR;
    logic [2:0]  FC;

    modport master (
        input  req_valid, req_rw, req_size, req_addr, req_wdata, req_fc, D_IN, DTACK, BERR,
        output req_ready, done, err, rdata, A, AS, UDS, LDS, RW, D_OUT, D_OE, FC
    );

    modport slave (
        output req_valid, req_rw, req_size, req_addr, req_wdata, req_fc, D_IN, DTACK, BERR,
        input  req_ready, done, err, rdata, A, AS, UDS, LDS, RW, D_OUT, D_OE, FC
    );
endinterface

// File: rtl/m68k_bus_watchdog.sv
// WAIT-state watchdog: cleared on strobe, counts cycles with no response, saturates at TIMEOUT.
module m68k_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && cnt_q != CW'(TIMEOUT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fires on the idle cycle whose increment would reach TIMEOUT.
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = enable && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/m68k_bus_unit.sv
// 68000 asynchronous-bus master: turns byte/word/long requests into AS/DS/DTACK bus cycles.
module m68k_bus_unit #(
    parameter int TIMEOUT     = 255,
    parameter int SETUP_CYC   = 1,
    parameter int RECOVER_CYC = 1
) (
    input logic      CLK,
    input logic      RESET,
    m68k_bus_if.master bus
);
    import m68k_bus_pkg::*;

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [23:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  fc_q, fc_d;
    logic        second_q, second_d;
    logic [1:0]  err_acc_q, err_acc_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        as_q, as_d, uds_q, uds_d, lds_q, lds_d, doe_q, doe_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wd_clear, wd_en, wd_expire, strobing;

    assign wd_clear = (state_q == ST_STROBE);
    assign wd_en    = (state_q == ST_WAIT) && !bus.BERR && !bus.DTACK;

    m68k_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        fc_d      = fc_q;
        second_d  = second_q;
        err_acc_d = err_acc_q;
        rbuf_d    = rbuf_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                addr_d    = bus.req_addr;
                rw_d      = bus.req_rw;
                size_d    = (bus.req_size == 2'b11) ? SIZE_WORD : bus.req_size;
                wdata_d   = bus.req_wdata;
                fc_d      = bus.req_fc;
                second_d  = 1'b0;
                cyc_d     = '0;
                if (size_d != SIZE_BYTE && bus.req_addr[0]) begin
                    err_acc_d = ERR_ADDR;
                    state_d   = ST_DONE;
                end else begin
                    err_acc_d = ERR_OK;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cyc_d = cyc_q + 8'd1;
                if (cyc_q == SETUP_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.BERR) begin
                    err_acc_d = ERR_BUS;
                    state_d   = ST_END;
                end else if (bus.DTACK) begin
                    if (rw_q == RW_READ) begin
                        if (size_q == SIZE_BYTE)
                            rbuf_d = {24'd0, addr_q[0] ? bus.D_IN[7:0] : bus.D_IN[15:8]};
                        else if (size_q == SIZE_LONG && !second_q)
                            rbuf_d = {bus.D_IN, 16'd0};
                        else if (size_q == SIZE_LONG)
                            rbuf_d = {rbuf_q[31:16], bus.D_IN};
                        else
                            rbuf_d = {16'd0, bus.D_IN};
                    end
                    state_d = ST_END;
                end else if (wd_expire) begin
                    err_acc_d = ERR_TIMEOUT;
                    state_d   = ST_END;
                end
            end
            ST_END: begin
                cyc_d = cyc_q + 8'd1;
                if (cyc_q == RECOVER_LAST) begin
                    cyc_d = '0;
                    // A failed first half of a long never runs its second half.
                    if (size_q == SIZE_LONG && !second_q && err_acc_q == ERR_OK) begin
                        second_d = 1'b1;
                        addr_d   = addr_q + 24'd2;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                err_d   = err_acc_q;
                rdata_d = rbuf_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes and D_OE are registered from the next state so they change cleanly on edges.
        strobing = (state_d == ST_STROBE) || (state_d == ST_WAIT);
        as_d     = strobing ? AS_STROBE : AS_OFF;
        uds_d    = (strobing && (size_d != SIZE_BYTE || !addr_d[0])) ? DS_ON : DS_OFF;
        lds_d    = (strobing && (size_d != SIZE_BYTE ||  addr_d[0])) ? DS_ON : DS_OFF;
        doe_d    = (strobing || state_d == ST_SETUP) && (rw_d == RW_WRITE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            addr_q    <= '0;
            rw_q      <= RW_READ;
            size_q    <= SIZE_BYTE;
            wdata_q   <= '0;
            fc_q      <= '0;
            second_q  <= 1'b0;
            err_acc_q <= ERR_OK;
            rbuf_q    <= '0;
            as_q      <= AS_OFF;
            uds_q     <= DS_OFF;
            lds_q     <= DS_OFF;
            doe_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            fc_q      <= fc_d;
            second_q  <= second_d;
            err_acc_q <= err_acc_d;
            rbuf_q    <= rbuf_d;
            as_q      <= as_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            doe_q     <= doe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.A         = addr_q[23:1];
    assign bus.AS        = as_q;
    assign bus.UDS       = uds_q;
    assign bus.LDS       = lds_q;
    assign bus.RW        = (state_q inside {ST_SETUP, ST_STROBE, ST_WAIT, ST_END}) ? rw_q : RW_READ;
    assign bus.D_OUT     = write_lane(wdata_q, size_q, second_q);
    assign bus.D_OE      = doe_q;
    assign bus.FC        = fc_q;
endmodule
